nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_if.sv | 40 ++++
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master side presents operands and accepts results; the slave side is the adder.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // Both channels use plain valid/ready: a transfer happens on a rising
    // edge where valid and ready are both 1. valid never depends
    // combinationally on ready.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder that builds A+B+cin one 4-bit nibble per clock.
// Flow: IDLE captures operands, ADD runs NIBBLES nibble adds, DONE holds the
// result until out_ready. Optional macro ADDER_OVF_EN adds a signed overflow flag.
// state_dbg exposes the FSM state for checkers.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    nibble_serial_adder_if.slave       bus,
    output logic [1:0]                 state_dbg
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         nib_sum;
    logic               last_nib;
    logic               capture;

    // Current nibble slice and its 4-bit full add.
    assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
    assign nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
    assign capture  = (state_q == IDLE) && bus.in_valid;

    // State register; reset drops straight back to IDLE, aborting any add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs, decoded from the registered state only.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = ADD;
            end
            ADD: begin
                if (last_nib) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and one nibble of the sum per ADD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (capture) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sum_q   <= '0;
            carry_q <= bus.cin;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == ADD) begin
            sum_q[{idx_q, 2'b00} +: 4] <= nib_sum[3:0];
            carry_q                    <= nib_sum[4];
            idx_q                      <= idx_q + IDX_W'(1);
            if (last_nib) cout_q <= nib_sum[4];
        end
    end

`ifdef ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: same-sign operands whose final sum top bit differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (capture) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ADD) && last_nib) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus randomized
// operands compared against plain integer addition.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_pass;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain W+1 bit addition.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        s = model_add(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    function automatic logic read_ovf();
`ifdef ADDER_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Driver: present one operand set, then wait (bounded) for out_valid.
    // Leaves the block in DONE with out_ready=0. lat counts edges after capture.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input bit poke_busy, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.cin       = tc;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = poke_busy;
        bus.a        = poke_busy ? 16'h1111 : W'($urandom);
        bus.b        = poke_busy ? 16'h1111 : W'($urandom);
        bus.cin      = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Driver: accept the result with one out_ready pulse.
    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.sum !== 16'h0000) $display("FAIL reset_sum: got %h want 0000", bus.sum); else n_pass++;
        n_checks++; if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", bus.cout); else n_pass++;
        n_checks++; if (read_ovf() !== 1'b0) $display("FAIL reset_ovf: got %b want 0", read_ovf()); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (lat !== NIBBLES) $display("FAIL wrap_latency: got %0d want %0d", lat, NIBBLES); else n_pass++;
        n_checks++; if (bus.sum !== 16'h0000) $display("FAIL wrap_sum: got %h want 0000", bus.sum); else n_pass++;
        n_checks++; if (bus.cout !== 1'b1) $display("FAIL wrap_cout: got %b want 1", bus.cout); else n_pass++;
        release_op();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL wrap_idle: in_ready got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_partial_sum();
        int full;
        int exp_part;
        full = 32'h1234 + 32'h4321 + 1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        n_checks++; if (bus.sum !== 16'h0000) $display("FAIL partial_cleared: got %h want 0000", bus.sum); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL partial_busy: in_ready got %b want 0", bus.in_ready); else n_pass++;
        for (int j = 1; j < NIBBLES; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp_part = full % (1 << (4 * j));
            n_checks++; if (bus.sum !== W'(exp_part)) $display("FAIL partial_sum_%0d: got %h want %h", j, bus.sum, W'(exp_part)); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL partial_early_valid_%0d: got %b want 0", j, bus.out_valid); else n_pass++;
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL partial_valid: got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.sum !== 16'h5556) $display("FAIL partial_final: got %h want 5556", bus.sum); else n_pass++;
        n_checks++; if (bus.cout !== 1'b0) $display("FAIL partial_cout: got %b want 0", bus.cout); else n_pass++;
        release_op();
        n_checks++; if (bus.sum !== 16'h5556) $display("FAIL partial_idle_hold: got %h want 5556", bus.sum); else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W:0] exp;
        exp = model_add(16'hA5A5, 16'h0F0F, 1'b0);
        run_op(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, lat);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", c, bus.out_valid); else n_pass++;
            n_checks++; if ({bus.cout, bus.sum} !== exp) $display("FAIL bp_result_%0d: got %b_%h want %b_%h", c, bus.cout, bus.sum, exp[W], exp[W-1:0]); else n_pass++;
        end
        release_op();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        run_op(16'h0002, 16'h0003, 1'b0, 1'b1, lat);
        n_checks++; if (bus.sum !== 16'h0005) $display("FAIL busy_sum: got %h want 0005", bus.sum); else n_pass++;
        n_checks++; if (lat !== NIBBLES) $display("FAIL busy_latency: got %0d want %0d", lat, NIBBLES); else n_pass++;
        release_op();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL busy_not_queued: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h7777; bus.b = 16'h1111; bus.cin = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.sum !== 16'h0000) $display("FAIL rstmid_sum: got %h want 0000", bus.sum); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (NIBBLES + 1) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_discarded: out_valid got %b want 0", bus.out_valid); else n_pass++;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (bus.sum !== 16'h0002) $display("FAIL rstmid_next_sum: got %h want 0002", bus.sum); else n_pass++;
        n_checks++; if (lat !== NIBBLES) $display("FAIL rstmid_latency: got %0d want %0d", lat, NIBBLES); else n_pass++;
        release_op();
    endtask

    task automatic test_ovf();
`ifdef ADDER_OVF_EN
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if ({bus.ovf, bus.cout, bus.sum} !== {1'b1, 1'b0, 16'h8000})
            $display("FAIL ovf_pos: got ovf %b cout %b sum %h want 1 0 8000", bus.ovf, bus.cout, bus.sum); else n_pass++;
        release_op();
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
        n_checks++; if ({bus.ovf, bus.cout, bus.sum} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL ovf_neg: got ovf %b cout %b sum %h want 1 1 0000", bus.ovf, bus.cout, bus.sum); else n_pass++;
        release_op();
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.ovf); else n_pass++;
        release_op();
`endif
    endtask

    task automatic test_random();
        int         lat;
        int         hold;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   exp;
        for (int t = 0; t < 30; t++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            hold = $urandom_range(0, 2);
            exp  = model_add(ra, rb, rc);
            run_op(ra, rb, rc, 1'($urandom), lat);
            n_checks++; if (lat !== NIBBLES) $display("FAIL rand_latency_%0d: got %0d want %0d", t, lat, NIBBLES); else n_pass++;
            n_checks++; if ({bus.cout, bus.sum} !== exp)
                $display("FAIL rand_result_%0d: %h+%h+%b got %b_%h want %b_%h", t, ra, rb, rc, bus.cout, bus.sum, exp[W], exp[W-1:0]); else n_pass++;
`ifdef ADDER_OVF_EN
            n_checks++; if (bus.ovf !== model_ovf(ra, rb, rc))
                $display("FAIL rand_ovf_%0d: got %b want %b", t, bus.ovf, model_ovf(ra, rb, rc)); else n_pass++;
`endif
            repeat (hold) @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp)
                $display("FAIL rand_hold_%0d: valid %b got %b_%h want 1 %b_%h", t, bus.out_valid, bus.cout, bus.sum, exp[W], exp[W-1:0]); else n_pass++;
            release_op();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_wrap();
        test_partial_sum();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_ovf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
